rmw_tbl_scheduler: RTL

- Front-end controller for the long-latency read-modify-write table (TBL).
- Accepts issue_t commands, allocates an in-flight tag per TBL lookup, and sends lookups to TBL.
- Collects out-of-order TBL responses, applies ADDI/SUBI, and emits one write-back per command.
- Enforces per-id ordering so that read-modify-write operations to the same id never overlap.

---
 rtl/rmw_long_latency_pkg.sv | 81 ++++++++
 rtl/rmw_tag_pool.sv | 53 +++++
 rtl/rmw_tbl_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rmw_long_latency_pkg.sv
// Shared types for the long-latency read-modify-write table front end:
// command/entry layouts, tag sizing and the small arithmetic helpers.
package rmw_long_latency_pkg;

    localparam int IN_FLIGHT_N = 16;
    localparam int TAG_W       = 4;
    localparam int CNT_W       = 5;

    typedef logic [15:0]            id_t;
    typedef logic [31:0]            word_t;
    typedef logic [TAG_W-1:0]       tag_t;
    typedef logic [IN_FLIGHT_N-1:0] vld_vec_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_MOVI = 2'd1,
        OP_ADDI = 2'd2,
        OP_SUBI = 2'd3
    } op_t;

    typedef struct packed {
        id_t   id;
        word_t imm;
        op_t   op;
    } issue_t;

    typedef struct packed {
        id_t  id;
        tag_t tag;
    } lk_t;

    typedef struct packed {
        tag_t  tag;
        word_t dat;
    } rsp_t;

    typedef struct packed {
        id_t   id;
        word_t dat;
    } wr_t;

    typedef struct packed {
        id_t   id;
        word_t imm;
        op_t   op;
    } tbl_entry_t;

    // Index of the lowest clear bit; only meaningful when one exists.
    function automatic tag_t clz_tag(input vld_vec_t vld);
        tag_t t;
        t = '0;
        for (int i = IN_FLIGHT_N - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                t = tag_t'(i);
            end
        end
        return t;
    endfunction

    function automatic cnt_t popcount(input vld_vec_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < IN_FLIGHT_N; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

    function automatic word_t compute(input op_t op, input word_t rd, input word_t imm);
        word_t r;
        case (op)
            OP_ADDI: r = rd + imm;
            OP_SUBI: r = rd - imm;
            OP_MOVI: r = imm;
            default: r = rd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rmw_tag_pool.sv
// In-flight tag bookkeeping: valid vector, lowest-free allocation,
// release on response and a registered occupancy count.
module rmw_tag_pool
    import rmw_long_latency_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     alloc_en,
    input  logic     free_en,
    input  tag_t     free_tag,
    output vld_vec_t vld,
    output logic     alloc_ok,
    output tag_t     alloc_tag,
    output cnt_t     cnt
);

    vld_vec_t vld_q;
    vld_vec_t vld_d;
    cnt_t     cnt_q;
    cnt_t     cnt_d;
    logic     full;

    // Allocation looks only at the registered vector, so a tag released
    // this cycle becomes allocatable from the next cycle on.
    assign full      = &vld_q;
    assign alloc_ok  = !full;
    assign alloc_tag = clz_tag(vld_q);

    always_comb begin
        vld_d = vld_q;
        if (free_en) begin
            vld_d[free_tag] = 1'b0;
        end
        if (alloc_en && alloc_ok) begin
            vld_d[alloc_tag] = 1'b1;
        end
        cnt_d = popcount(vld_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign vld = vld_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/rmw_tbl_scheduler.sv
// Front-end scheduler for the long-latency RMW table: tags lookups, keeps
// same-id operations serialized and turns responses into write-backs.
module rmw_tbl_scheduler
    import rmw_long_latency_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    input  logic [$bits(issue_t)-1:0] in,
    output logic                      in_accept,
    output logic                      lk_vld,
    output logic [15:0]               lk_id,
    output logic [TAG_W-1:0]          lk_tag,
    input  logic                      lk_accept,
    input  logic                      rsp_vld,
    input  logic [TAG_W-1:0]          rsp_tag,
    input  logic [31:0]               rsp_dat,
    output logic                      wr_vld,
    output logic [15:0]               wr_id,
    output logic [31:0]               wr_dat,
    output logic [CNT_W-1:0]          in_flight_cnt
);

    issue_t     cmd;
    rsp_t       rsp;
    vld_vec_t   tag_vld;
    logic       alloc_ok;
    tag_t       alloc_tag;
    cnt_t       pool_cnt;
    logic       hz;
    logic       acc;
    logic       rmw_acc;
    logic       movi_acc;
    tbl_entry_t rsp_ent;

    tbl_entry_t ent_q [IN_FLIGHT_N];
    tbl_entry_t ent_d [IN_FLIGHT_N];

    lk_t  lk_q;
    lk_t  lk_d;
    logic lk_vld_q;
    logic lk_vld_d;
    wr_t  wr_q;
    wr_t  wr_d;
    logic wr_vld_q;
    logic wr_vld_d;

    assign cmd = issue_t'(in);
    assign rsp = '{tag: rsp_tag, dat: rsp_dat};

    rmw_tag_pool u_pool (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (rmw_acc),
        .free_en   (rsp_vld),
        .free_tag  (rsp.tag),
        .vld       (tag_vld),
        .alloc_ok  (alloc_ok),
        .alloc_tag (alloc_tag),
        .cnt       (pool_cnt)
    );

    // Hazard uses the pre-free vector: a same-id command waits one extra
    // cycle after the response, keeping write-backs in acceptance order.
    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < IN_FLIGHT_N; i++) begin
            if (tag_vld[i] && (ent_q[i].id == cmd.id)) begin
                hz = 1'b1;
            end
        end
        hz = hz && in_vld;
    end

    always_comb begin
        in_accept = 1'b0;
        if (!rst) begin
            case (cmd.op)
                OP_NOP:  in_accept = 1'b1;
                OP_MOVI: in_accept = !hz && !rsp_vld;
                default: in_accept = !hz && alloc_ok && (!lk_vld_q || lk_accept);
            endcase
        end
    end

    assign acc      = in_vld && in_accept;
    assign rmw_acc  = acc && ((cmd.op == OP_ADDI) || (cmd.op == OP_SUBI));
    assign movi_acc = acc && (cmd.op == OP_MOVI);
    assign rsp_ent  = ent_q[rsp.tag];

    always_comb begin
        ent_d = ent_q;
        if (rmw_acc) begin
            ent_d[alloc_tag] = '{id: cmd.id, imm: cmd.imm, op: cmd.op};
        end
    end

    // Entry payload is only read behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        lk_vld_d = lk_vld_q;
        lk_d     = lk_q;
        if (rmw_acc) begin
            lk_vld_d = 1'b1;
            lk_d     = '{id: cmd.id, tag: alloc_tag};
        end else if (lk_accept) begin
            lk_vld_d = 1'b0;
        end
    end

    // A response always owns the write-back port; MOVI is held off when
    // rsp_vld is high, so the two never collide here.
    always_comb begin
        wr_vld_d = 1'b0;
        wr_d     = wr_q;
        if (rsp_vld) begin
            wr_vld_d = 1'b1;
            wr_d     = '{id: rsp_ent.id, dat: compute(rsp_ent.op, rsp.dat, rsp_ent.imm)};
        end else if (movi_acc) begin
            wr_vld_d = 1'b1;
            wr_d     = '{id: cmd.id, dat: cmd.imm};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_vld_q <= 1'b0;
            lk_q     <= '0;
            wr_vld_q <= 1'b0;
            wr_q     <= '0;
        end else begin
            lk_vld_q <= lk_vld_d;
            lk_q     <= lk_d;
            wr_vld_q <= wr_vld_d;
            wr_q     <= wr_d;
        end
    end

    assign lk_vld        = lk_vld_q;
    assign lk_id         = lk_q.id;
    assign lk_tag        = lk_q.tag;
    assign wr_vld        = wr_vld_q;
    assign wr_id         = wr_q.id;
    assign wr_dat        = wr_q.dat;
    assign in_flight_cnt = pool_cnt;

    a_rsp_tag_valid : assert property (@(posedge clk) disable iff (rst)
        rsp_vld |-> tag_vld[rsp.tag]);

    a_rsp_after_lookup : assert property (@(posedge clk) disable iff (rst)
        (rsp_vld && lk_vld_q) |-> (rsp.tag != lk_q.tag));

    a_cnt_range : assert property (@(posedge clk) disable iff (rst)
        in_flight_cnt <= 5'd16);

    a_no_x_out : assert property (@(posedge clk) disable iff (rst)
        !$isunknown({in_accept, lk_vld, lk_id, lk_tag, wr_vld, wr_id, wr_dat, in_flight_cnt}));

endmodule
